// File: rtl/flit_mux2.sv
// 2:1 flit multiplexer with packet lock (HEAD..TAIL) and a registered output.
// Optional output flit counter enabled by defining MUX_FLITCNT_EN.
module flit_mux2 #(
    parameter int DATA_W = 39,
    parameter int VCH_W  = 2,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
`ifdef MUX_FLITCNT_EN
    ,
    output logic [15:0]       flit_cnt
`endif
);

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic [VCH_W-1:0]  vch;
    } flit_t;

    state_t     state, state_n;
    logic       lock_port, lock_port_n;
    logic       port, port_ok, load;
    logic [1:0] ftype;
    flit_t      sel_flit, nxt_flit, out_q;

    // Only the two low select bits address a port; the rest are don't-care.
    logic unused_sel;
    assign unused_sel = ^sel[SEL_W-1:2];

    always_comb begin
        port_ok     = 1'b0;
        port        = 1'b0;
        state_n     = state;
        lock_port_n = lock_port;

        if (state == LOCKED) begin
            port_ok = 1'b1;
            port    = lock_port;
        end else begin
            case (sel[1:0])
                2'b01:   begin port_ok = 1'b1; port = 1'b0; end
                2'b10:   begin port_ok = 1'b1; port = 1'b1; end
                default: begin port_ok = 1'b0; port = 1'b0; end
            endcase
        end

        sel_flit = port ? '{data: idata_1, valid: ivalid_1, vch: ivch_1}
                        : '{data: idata_0, valid: ivalid_0, vch: ivch_0};
        load     = port_ok && sel_flit.valid;
        nxt_flit = load ? sel_flit : '0;
        ftype    = sel_flit.data[DATA_W-1 -: 2];

        if (state == IDLE && load && ftype == FT_HEAD) begin
            state_n     = LOCKED;
            lock_port_n = port;
        end else if (state == LOCKED && load && ftype == FT_TAIL) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= IDLE;
            lock_port <= 1'b0;
            out_q     <= '0;
        end else begin
            state     <= state_n;
            lock_port <= lock_port_n;
            out_q     <= nxt_flit;
        end
    end

    assign odata  = out_q.data;
    assign ovalid = out_q.valid;
    assign ovch   = out_q.vch;

`ifdef MUX_FLITCNT_EN
    logic [15:0] cnt;

    // Free-running count of forwarded flits, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_)               cnt <= '0;
        else if (nxt_flit.valid) cnt <= cnt + 16'd1;
    end

    assign flit_cnt = cnt;
`endif

endmodule

// File: tb/tb_flit_mux2.sv
// Scoreboard bench for flit_mux2: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry per clock after the output register updates.
module tb_flit_mux2;

    localparam int DW = 39;
    localparam int VW = 2;
    localparam int SW = 5;
    localparam logic [1:0] HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11;

    typedef struct {
        logic [DW-1:0] d;
        logic          v;
        logic [VW-1:0] c;
        logic          rst;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_;
    logic [DW-1:0] idata_0, idata_1, odata;
    logic          ivalid_0, ivalid_1, ovalid;
    logic [VW-1:0] ivch_0, ivch_1, ovch;
    logic [SW-1:0] sel;
`ifdef MUX_FLITCNT_EN
    logic [15:0]   flit_cnt;
    logic [15:0]   mcnt = '0;
`endif

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    flit_mux2 #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel),
        .odata(odata), .ovalid(ovalid), .ovch(ovch)
`ifdef MUX_FLITCNT_EN
        , .flit_cnt(flit_cnt)
`endif
    );

    function automatic logic [DW-1:0] fl(input logic [1:0] t, input int p);
        return {t, 37'(p)};
    endfunction

    // One clock of stimulus plus the flit expected on the output after the next edge.
    task automatic cyc(input logic r, input logic [SW-1:0] s,
                       input logic [DW-1:0] d0, input logic v0, input logic [VW-1:0] c0,
                       input logic [DW-1:0] d1, input logic v1, input logic [VW-1:0] c1,
                       input logic [DW-1:0] ed, input logic ev, input logic [VW-1:0] ec);
        exp_t e;
        @(negedge clk);
        rst_ = r; sel = s;
        idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
        idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
        e.d = ed; e.v = ev; e.c = ec; e.rst = ~r;
        q.push_back(e);
    endtask

    task automatic idle();
        cyc(1, 5'b00001, '0, 0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: output is valid every cycle (no handshake), so pop once per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (odata !== e.d || ovalid !== e.v || ovch !== e.c) begin
                    miscompares++;
                    $display("FAIL flit vec%0d: got %h/%b/%0d want %h/%b/%0d",
                             vectors, odata, ovalid, ovch, e.d, e.v, e.c);
                end
`ifdef MUX_FLITCNT_EN
                if (e.rst) mcnt = '0;
                else if (e.v) mcnt = mcnt + 16'd1;
                if (flit_cnt !== mcnt) begin
                    miscompares++;
                    $display("FAIL flit_cnt vec%0d: got %0d want %0d", vectors, flit_cnt, mcnt);
                end
`endif
            end
        end
    end

    initial begin
        logic [DW-1:0] f0, f1;
        logic [1:0]    t;
        rst_ = 0; sel = '0; idata_0 = '0; ivalid_0 = 0; ivch_0 = 0;
        idata_1 = '0; ivalid_1 = 0; ivch_1 = 0;

        // Reset holds output at zero even with a valid HEAD selected.
        repeat (2) cyc(0, 5'b00001, fl(HEAD, 'h11), 1, 1, '0, 0, 0, '0, 0, 0);
        cyc(1, 5'b00001, fl(DATA, 'h12), 1, 1, '0, 0, 0, fl(DATA, 'h12), 1, 1);

        // Input 1 packet; input 0 traffic must never appear.
        for (int i = 0; i < 22; i++) begin
            t  = (i == 0) ? HEAD : (i == 21) ? TAIL : DATA;
            f1 = fl(t, 'h100 + i);
            cyc(1, 5'b00010, fl(HEAD, 'h900 + i), 1, 1, f1, 1, 2, f1, 1, 2);
        end

        // Lock on input 0 survives a select change; input 1 follows after the TAIL.
        for (int i = 0; i < 9; i++) begin
            t  = (i == 0) ? HEAD : (i == 6) ? TAIL : DATA;
            f0 = fl(t, 'h200 + i);
            f1 = fl(DATA, 'h300 + i);
            if (i < 4)       cyc(1, 5'b00001, f0, 1, 1, f1, 1, 3, f0, 1, 1);
            else if (i < 7)  cyc(1, 5'b00010, f0, 1, 1, f1, 1, 3, f0, 1, 1);
            else             cyc(1, 5'b00010, f0, 1, 1, f1, 1, 3, f1, 1, 3);
        end

        // Bad selects while IDLE; upper select bits are ignored.
        cyc(1, 5'b00000, fl(HEAD, 'h400), 1, 1, fl(HEAD, 'h401), 1, 2, '0, 0, 0);
        cyc(1, 5'b00011, fl(HEAD, 'h402), 1, 1, fl(HEAD, 'h403), 1, 2, '0, 0, 0);
        cyc(1, 5'b11100, fl(HEAD, 'h404), 1, 1, fl(HEAD, 'h405), 1, 2, '0, 0, 0);
        cyc(1, 5'b11101, fl(DATA, 'h406), 1, 1, fl(DATA, 'h407), 1, 2, fl(DATA, 'h406), 1, 1);
        cyc(1, 5'b11110, fl(DATA, 'h408), 1, 1, fl(DATA, 'h409), 1, 2, fl(DATA, 'h409), 1, 2);

        // Gaps keep the lock; a HEAD while locked is forwarded without effect.
        cyc(1, 5'b00001, fl(HEAD, 'h500), 1, 0, fl(DATA, 'h600), 1, 1, fl(HEAD, 'h500), 1, 0);
        cyc(1, 5'b00001, fl(DATA, 'h501), 1, 0, fl(DATA, 'h601), 1, 1, fl(DATA, 'h501), 1, 0);
        for (int i = 0; i < 7; i++)
            cyc(1, 5'b00010, fl(DATA, 'h510 + i), 0, 0, fl(HEAD, 'h610 + i), 1, 1, '0, 0, 0);
        cyc(1, 5'b00010, fl(HEAD, 'h520), 1, 0, fl(DATA, 'h620), 1, 1, fl(HEAD, 'h520), 1, 0);
        cyc(1, 5'b00010, fl(DATA, 'h521), 1, 0, fl(DATA, 'h621), 1, 1, fl(DATA, 'h521), 1, 0);
        cyc(1, 5'b00010, fl(TAIL, 'h522), 1, 0, fl(DATA, 'h622), 1, 1, fl(TAIL, 'h522), 1, 0);
        cyc(1, 5'b00010, fl(DATA, 'h523), 1, 0, fl(DATA, 'h623), 1, 1, fl(DATA, 'h623), 1, 1);

        // Reset mid-packet drops the lock.
        cyc(1, 5'b00001, fl(HEAD, 'h700), 1, 2, fl(DATA, 'h800), 1, 3, fl(HEAD, 'h700), 1, 2);
        cyc(0, 5'b00001, fl(DATA, 'h701), 1, 2, fl(DATA, 'h801), 1, 3, '0, 0, 0);
        cyc(1, 5'b00010, fl(DATA, 'h702), 1, 2, fl(DATA, 'h802), 1, 3, fl(DATA, 'h802), 1, 3);
        idle();
        drain();

`ifdef MUX_FLITCNT_EN
        cyc(0, 5'b00001, '0, 0, 0, '0, 0, 0, '0, 0, 0);
        for (int p = 0; p < 10; p++)
            for (int i = 0; i < 22; i++) begin
                t  = (i == 0) ? HEAD : (i == 21) ? TAIL : DATA;
                f0 = fl(t, p * 32 + i);
                cyc(1, 5'b00001, f0, 1, 1, '0, 0, 0, f0, 1, 1);
            end
        idle();
        drain();
        vectors++;
        if (flit_cnt !== 16'd220) begin
            miscompares++;
            $display("FAIL cnt220: got %0d want 220", flit_cnt);
        end
        for (int i = 220; i < 65535; i++)
            cyc(1, 5'b00001, fl(DATA, i), 1, 0, '0, 0, 0, fl(DATA, i), 1, 0);
        idle();
        drain();
        vectors++;
        if (flit_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL cnt_max: got %h want ffff", flit_cnt);
        end
        cyc(1, 5'b00001, fl(DATA, 'h1), 1, 0, '0, 0, 0, fl(DATA, 'h1), 1, 0);
        idle();
        drain();
        vectors++;
        if (flit_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %h want 0000", flit_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
